// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one programmable clock divider among NREQ requesters.
// A granted requester gets a burst of len full divided-clock periods at its ratio.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int RW   = 4,
  parameter int LW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*RW-1:0]   ratio,
  input  logic [NREQ*LW-1:0]   len,
  output logic [NREQ-1:0]      gnt,
  output logic                 div_out,
  output logic                 tick,
  output logic                 done,
  output logic                 aborted,
  output logic                 busy,
  output logic [RW-1:0]        cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_ptr, r_idx;
  logic [RW-1:0]   r_rq, r_cnt;
  logic [LW-1:0]   r_lq, r_per;
  logic            r_div, r_tick, r_abort, r_ab_res;

  logic            w_found;
  logic [IW-1:0]   w_sel, w_probe;
  logic [RW-1:0]   w_rsel, w_re;
  logic [LW-1:0]   w_lsel, w_le;
  logic [RW:0]     w_cnt_inc;
  logic            w_wrap, w_fall, w_last, w_abort_set, w_abort_now, w_end;

  // First pending request at or above the rr pointer, wrapping modulo NREQ.
  // NOTE: every comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_probe = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_probe = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_probe]) begin
        w_found = 1'b1;
        w_sel   = w_probe;
      end
    end
    w_rsel = ratio[int'(w_sel)*RW +: RW];
    w_lsel = len[int'(w_sel)*LW +: LW];
  end

  assign w_re        = (r_rq == '0) ? RW'(1) : r_rq;
  assign w_le        = (r_lq == '0) ? LW'(1) : r_lq;
  assign w_cnt_inc   = {1'b0, r_cnt} + {{RW{1'b0}}, 1'b1};
  assign w_wrap      = (w_cnt_inc >= {1'b0, w_re});
  assign w_fall      = w_wrap & r_div;
  assign w_last      = w_fall & (({1'b0, r_per} + {{LW{1'b0}}, 1'b1}) == {1'b0, w_le});
  // An abort is either already latched or being seen this cycle on the granted line.
  assign w_abort_set = r_abort | ~(|(req & r_gnt));
  assign w_abort_now = w_abort_set & ~r_div & (r_cnt == '0);
  assign w_end       = w_last | (w_abort_set & (w_fall | w_abort_now));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are reset so an aborted burst can never leave stale grant or phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_rq     <= '0;
      r_lq     <= '0;
      r_cnt    <= '0;
      r_per    <= '0;
      r_div    <= 1'b0;
      r_tick   <= 1'b0;
      r_abort  <= 1'b0;
      r_ab_res <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx <= w_sel;
            r_gnt <= NREQ'(1) << w_sel;
            r_rq  <= w_rsel;
            r_lq  <= w_lsel;
          end
        end
        S_LOAD: begin
          r_cnt    <= '0;
          r_div    <= 1'b0;
          r_per    <= '0;
          r_abort  <= 1'b0;
          r_ab_res <= 1'b0;
        end
        S_RUN: begin
          r_abort <= w_abort_set;
          if (w_abort_now) begin
            // Low phase and counter at zero: stop without starting another high phase.
            r_gnt    <= '0;
            r_ab_res <= 1'b1;
          end else if (w_wrap) begin
            r_cnt  <= '0;
            r_div  <= ~r_div;
            r_tick <= 1'b1;
            if (r_div) begin
              r_per <= r_per + 1'b1;
              if (w_end) begin
                r_gnt    <= '0;
                r_ab_res <= ~w_last;
              end
            end
          end else begin
            r_cnt <= w_cnt_inc[RW-1:0];
          end
        end
        S_DONE: r_ptr <= (r_idx == IW'(NREQ-1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign div_out = r_div;
  assign tick    = r_tick;
  assign cnt     = r_cnt;

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    aborted = (r_state == S_DONE) & r_ab_res;
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: per-burst waveform expectations are computed
// from period arithmetic and a round-robin pointer model, not from the RTL structure.
module tb_div_arbiter;
  localparam int NREQ = 4;
  localparam int RW   = 4;
  localparam int LW   = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*RW-1:0]  ratio = '0;
  logic [NREQ*LW-1:0]  len = '0;
  logic [NREQ-1:0]     gnt;
  logic                div_out, tick, done, aborted, busy;
  logic [RW-1:0]       cnt;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_r [NREQ];
  int m_l [NREQ];

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .RW(RW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ratio(ratio), .len(len),
    .gnt(gnt), .div_out(div_out), .tick(tick), .done(done),
    .aborted(aborted), .busy(busy), .cnt(cnt)
  );

  function automatic int pick(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic raise(input int i, input int r, input int l);
    ratio[i*RW +: RW] = RW'(r);
    len[i*LW +: LW]   = LW'(l);
    m_r[i] = r;
    m_l[i] = l;
    req[i] = 1'b1;
  endtask

  // Follows one burst from grant to return to IDLE; drop_t<0 means the request is held.
  task automatic observe_burst(input int idx, input int r, input int l,
                               input int drop_t, input bit scramble);
    int re, le, tt, t_end, t_a, te, nticks, exp_ticks, waited;
    bit ab, imm;
    logic [NREQ-1:0] e_gnt;
    logic e_div, e_tick, e_done, e_ab, e_busy;
    logic [RW-1:0] e_cnt;
    re = (r == 0) ? 1 : r;
    le = (l == 0) ? 1 : l;
    tt = 2 * re * le;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == '0 && waited < 200);
    checks++;
    if (gnt !== NREQ'(1 << idx) || waited != 1 || busy !== 1'b1 || div_out !== 1'b0) begin
      errors++;
      $display("FAIL grant idx=%0d: got gnt=%b after %0d cycles busy=%b div=%b, want gnt=%b after 1 cycle busy=1 div=0",
               idx, gnt, waited, busy, div_out, NREQ'(1 << idx));
    end
    if (gnt === '0) return;
    if (scramble) begin
      ratio[idx*RW +: RW] = RW'($urandom);
      len[idx*LW +: LW]   = LW'($urandom);
    end
    t_end = tt; ab = 0; imm = 0;
    if (drop_t >= 0) begin
      t_a = drop_t + 1;
      if (t_a <= tt) begin
        if (((t_a - 1) / re) % 2 == 0 && (t_a - 1) % re == 0) begin
          t_end = t_a; ab = 1; imm = 1;
        end else begin
          te = ((t_a + 2*re - 1) / (2*re)) * (2*re);
          if (te < tt) begin
            t_end = te; ab = 1;
          end
        end
      end
    end
    nticks = 0;
    for (int t = 0; t <= t_end + 1; t++) begin
      @(negedge clk);
      e_ab = 1'b0;
      if (t < t_end) begin
        e_gnt = NREQ'(1 << idx); e_done = 1'b0; e_busy = 1'b1;
        e_div  = (t == 0) ? 1'b0 : (((t / re) % 2) == 1);
        e_tick = (t > 0) && (t % re == 0);
        e_cnt  = RW'(t % re);
      end else if (t == t_end) begin
        e_gnt = '0; e_done = 1'b1; e_busy = 1'b1; e_div = 1'b0;
        e_tick = !imm; e_ab = ab; e_cnt = '0;
      end else begin
        e_gnt = '0; e_done = 1'b0; e_busy = 1'b0; e_div = 1'b0;
        e_tick = 1'b0; e_cnt = '0;
      end
      checks++;
      if ({gnt, div_out, tick, done, aborted, busy, cnt} !==
          {e_gnt, e_div, e_tick, e_done, e_ab, e_busy, e_cnt}) begin
        errors++;
        $display("FAIL burst idx=%0d R=%0d L=%0d t=%0d: got gnt=%b div=%b tick=%b done=%b ab=%b busy=%b cnt=%0d, want gnt=%b div=%b tick=%b done=%b ab=%b busy=%b cnt=%0d",
                 idx, r, l, t, gnt, div_out, tick, done, aborted, busy, cnt,
                 e_gnt, e_div, e_tick, e_done, e_ab, e_busy, e_cnt);
      end
      if (tick === 1'b1) nticks++;
      if (t == drop_t) req[idx] = 1'b0;
    end
    exp_ticks = imm ? (t_end - 1) / re : t_end / re;
    checks++;
    if (nticks != exp_ticks) begin
      errors++;
      $display("FAIL tick_count idx=%0d: got %0d, want %0d", idx, nticks, exp_ticks);
    end
    m_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, div_out, tick, done, aborted, busy, cnt} !== '0) begin
      errors++;
      $display("FAIL reset: got gnt=%b div=%b tick=%b done=%b ab=%b busy=%b cnt=%0d, want all 0",
               gnt, div_out, tick, done, aborted, busy, cnt);
    end
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    raise(0, 2, 1);
    observe_burst(0, 2, 1, -1, 1'b0);
    req[0] = 1'b0;
  endtask

  task automatic test_zero();
    raise(3, 0, 0);
    observe_burst(3, 0, 0, -1, 1'b0);
    req[3] = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) raise(i, 1, 1);
    for (int k = 0; k < 5; k++) observe_burst(order[k], 1, 1, -1, 1'b0);
    req = '0;
  endtask

  task automatic test_abort();
    int nxt;
    raise(1, 4, 5);
    observe_burst(1, 4, 5, 5, 1'b0);
    req = '0;
    raise(0, 1, 1);
    raise(2, 1, 1);
    nxt = pick(req);
    checks++;
    if (nxt != 2) begin
      errors++;
      $display("FAIL abort_ptr: model picks %0d, want 2", nxt);
    end
    observe_burst(2, 1, 1, -1, 1'b0);
    req = '0;
  endtask

  task automatic test_reset_mid_run();
    int waited;
    raise(1, 2, 2);
    raise(3, 3, 4);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == '0 && waited < 200);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_grant: got gnt=%b, want 1000", gnt);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, div_out, tick, done, aborted, busy, cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got gnt=%b div=%b tick=%b done=%b ab=%b busy=%b cnt=%0d, want all 0",
               gnt, div_out, tick, done, aborted, busy, cnt);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    observe_burst(pick(req), m_r[1], m_l[1], -1, 1'b0);
    req[1] = 1'b0;
    observe_burst(3, 3, 4, -1, 1'b0);
    req = '0;
  endtask

  task automatic test_limits();
    raise(2, 15, 15);
    observe_burst(2, 15, 15, -1, 1'b0);
    req = '0;
  endtask

  task automatic test_random();
    int exp_idx, re, le, drop;
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          raise(i, $urandom_range(0, 15), $urandom_range(0, 3));
      if (req == '0) raise($urandom_range(0, NREQ-1), $urandom_range(0, 15), $urandom_range(0, 3));
      exp_idx = pick(req);
      re = (m_r[exp_idx] == 0) ? 1 : m_r[exp_idx];
      le = (m_l[exp_idx] == 0) ? 1 : m_l[exp_idx];
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2*re*le - 1) : -1;
      observe_burst(exp_idx, m_r[exp_idx], m_l[exp_idx], drop, 1'b1);
      req[exp_idx] = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_abort();
    test_reset_mid_run();
    test_limits();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
